// File: rtl/systolic_array_controller.sv
// Batch sequencer for a systolic array: weight-load pulse, skewed activation feed, deskewed results.
// Optional SYSTOLIC_CTRL_PERF_EN adds stall and batch cycle counters.
module systolic_array_controller #(
  parameter int SYSTOLIC_ARRAY_ROWS = 8,
  parameter int SYSTOLIC_ARRAY_COLS = 8,
  parameter int FIXED_POINT_WIDTH   = 16,
  parameter int SUM_WIDTH           = FIXED_POINT_WIDTH + 7,
  parameter int VEC_COUNT_WIDTH     = 10
) (
  input  logic                                           clk_in,
  input  logic                                           rst_n_in,
  input  logic                                           start_in,
  input  logic [VEC_COUNT_WIDTH-1:0]                     num_vectors_in,
  output logic                                           busy_out,
  output logic                                           done_out,
  output logic                                           weights_valid_out,
  input  logic                                           act_valid_in,
  input  logic [SYSTOLIC_ARRAY_ROWS*FIXED_POINT_WIDTH-1:0] act_in,
  output logic                                           act_ready_out,
  output logic [SYSTOLIC_ARRAY_ROWS*FIXED_POINT_WIDTH-1:0] array_act_out,
  input  logic [SYSTOLIC_ARRAY_COLS*SUM_WIDTH-1:0]       array_sum_in,
  output logic                                           result_valid_out,
  output logic [SYSTOLIC_ARRAY_COLS*SUM_WIDTH-1:0]       result_out
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]                                    stall_cycles_out,
  output logic [31:0]                                    batch_cycles_out
`endif
);

  localparam int ROWS = SYSTOLIC_ARRAY_ROWS;
  localparam int COLS = SYSTOLIC_ARRAY_COLS;
  localparam int FPW  = FIXED_POINT_WIDTH;
  localparam int SW   = SUM_WIDTH;
  localparam int LAT  = ROWS + COLS;
  localparam logic [VEC_COUNT_WIDTH-1:0] VEC_ONE = 1;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [VEC_COUNT_WIDTH-1:0] count_reg;
  logic [VEC_COUNT_WIDTH-1:0] issued_reg;
  logic [LAT-1:0]             vline_reg;
  logic                       accept;
  logic                       issue;
  logic [ROWS*FPW-1:0]        issue_vec;

  assign accept            = (state_reg == IDLE) && start_in;
  assign busy_out          = (state_reg == LOAD) || (state_reg == STREAM) || (state_reg == DRAIN);
  assign done_out          = (state_reg == DONE);
  assign weights_valid_out = (state_reg == LOAD);
  assign act_ready_out     = (state_reg == STREAM) && (issued_reg < count_reg);
  assign issue             = act_valid_in && act_ready_out;
  assign issue_vec         = issue ? act_in : '0;
  assign result_valid_out  = vline_reg[LAT-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      issued_reg <= '0;
      vline_reg  <= '0;
    end else begin
      state_reg <= state_next;
      vline_reg <= {vline_reg[LAT-2:0], issue};
      if (accept) begin
        count_reg  <= num_vectors_in;
        issued_reg <= '0;
      end else if (issue) begin
        issued_reg <= issued_reg + VEC_ONE;
      end
    end
  end

  // Leave STREAM on the cycle of the final issue so no idle STREAM cycle follows it.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_in) state_next = LOAD;
      LOAD:    state_next = (count_reg == '0) ? DONE : STREAM;
      STREAM:  if (issue && ((issued_reg + VEC_ONE) == count_reg)) state_next = DRAIN;
      DRAIN:   if (vline_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
        assign array_act_out[FPW-1:0] = issue_vec[FPW-1:0];
      end else begin : g_delay
        logic [FPW-1:0] skew_reg [gi];
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) begin
            for (int k = 0; k < gi; k++) skew_reg[k] <= '0;
          end else begin
            skew_reg[0] <= issue_vec[gi*FPW +: FPW];
            for (int k = 1; k < gi; k++) skew_reg[k] <= skew_reg[k-1];
          end
        end
        assign array_act_out[gi*FPW +: FPW] = skew_reg[gi-1];
      end
    end

    for (gi = 0; gi < COLS; gi++) begin : g_deskew
      localparam int DEPTH = COLS - 1 - gi;
      logic [SW-1:0] aligned;
      logic [SW-1:0] res_reg;
      if (DEPTH == 0) begin : g_direct
        assign aligned = array_sum_in[gi*SW +: SW];
      end else begin : g_delay
        logic [SW-1:0] dly_reg [DEPTH];
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) begin
            for (int k = 0; k < DEPTH; k++) dly_reg[k] <= '0;
          end else begin
            dly_reg[0] <= array_sum_in[gi*SW +: SW];
            for (int k = 1; k < DEPTH; k++) dly_reg[k] <= dly_reg[k-1];
          end
        end
        assign aligned = dly_reg[DEPTH-1];
      end
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) res_reg <= '0;
        else           res_reg <= aligned;
      end
      assign result_out[gi*SW +: SW] = res_reg;
    end
  endgenerate

`ifdef SYSTOLIC_CTRL_PERF_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cycles_out <= '0;
      batch_cycles_out <= '0;
    end else if (accept) begin
      stall_cycles_out <= '0;
      batch_cycles_out <= '0;
    end else begin
      if ((state_reg == STREAM) && !issue && (stall_cycles_out != '1))
        stall_cycles_out <= stall_cycles_out + 32'd1;
      if ((busy_out || done_out) && (batch_cycles_out != '1))
        batch_cycles_out <= batch_cycles_out + 32'd1;
    end
  end
`endif

endmodule
